// File: rtl/mem_access.sv
// -----------------------------------------------------------------------------
// mem_access -- MEM-stage load/store unit.
//
// Takes a load or store from the EX/MEM register and turns it into a byte-count
// request towards mem_buffer. The request is held until mem_buffer's completion
// strobe arrives. Load data is then sign- or zero-extended and handed to MEM/WB.
// The pipeline stalls while an access is outstanding. Non-memory instructions
// pass straight through to MEM/WB with no added latency.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_i, store_i   EX/MEM instruction is a load / store (load wins if both)
//   funct3_i          RISC-V funct3 (access width and signedness)
//   addr_i            effective address (truncated to 17 bits)
//   store_data_i      rs2 value for stores
//   wd_i, wreg_i      destination register and its write enable
//   wdata_i           ALU result for non-load instructions
//   mem_data_i        load data from mem_buffer
//   mem_data_enable   access-complete strobe from mem_buffer
//   mem_read_req      read byte count (00 none, 01 byte, 10 half, 11 word)
//   mem_write_req     write byte count, same encoding
//   mem_addr_o        byte address to mem_buffer
//   mem_write_data    store data, full word (buffer uses the low bytes)
//   wd_o, wreg_o      to MEM/WB
//   wdata_o           to MEM/WB
//   stall_req         hold the IF..EX/MEM stages
// -----------------------------------------------------------------------------
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_data_enable,
  output logic [1:0]  mem_read_req,
  output logic [1:0]  mem_write_req,
  output logic [16:0] mem_addr_o,
  output logic [31:0] mem_write_data,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stall_req
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q,   state_d;
  logic        is_load_q, is_load_d;
  logic [2:0]  funct3_q,  funct3_d;
  logic [16:0] addr_q,    addr_d;
  logic [31:0] sdata_q,   sdata_d;
  logic [4:0]  wd_q,      wd_d;
  logic        wreg_q,    wreg_d;
  logic [31:0] rdata_q,   rdata_d;

  // Address bits above the 17-bit buffer space are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:17];

  // Byte count of the access encoded as 01 byte, 10 half, 11 word.
  function automatic logic [1:0] req_width(input logic is_load, input logic [2:0] f3);
    logic [1:0] w;
    if (is_load) begin
      case (f3)
        3'b000, 3'b100: w = 2'b01;
        3'b001, 3'b101: w = 2'b10;
        default:        w = 2'b11;
      endcase
    end else begin
      case (f3)
        3'b000:  w = 2'b01;
        3'b001:  w = 2'b10;
        default: w = 2'b11;
      endcase
    end
    return w;
  endfunction

  // Sign/zero extension of returned load data according to funct3.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      3'b000:  r = {{24{d[7]}}, d[7:0]};
      3'b001:  r = {{16{d[15]}}, d[15:0]};
      3'b100:  r = {24'h000000, d[7:0]};
      3'b101:  r = {16'h0000, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // State and captured-operation registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      addr_q    <= 17'h00000;
      sdata_q   <= 32'h00000000;
      wd_q      <= 5'd0;
      wreg_q    <= 1'b0;
      rdata_q   <= 32'h00000000;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      wd_q      <= wd_d;
      wreg_q    <= wreg_d;
      rdata_q   <= rdata_d;
    end
  end

  // Next-state logic: capture in IDLE, wait for the strobe in BUSY, one DONE cycle.
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    wd_d      = wd_q;
    wreg_d    = wreg_q;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (load_i || store_i) begin
          state_d   = S_BUSY;
          is_load_d = load_i;
          funct3_d  = funct3_i;
          addr_d    = addr_i[16:0];
          sdata_d   = store_data_i;
          wd_d      = wd_i;
          wreg_d    = wreg_i;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_BUSY: begin
        if (mem_data_enable) begin
          state_d = S_DONE;
          rdata_d = load_extend(funct3_q, mem_data_i);
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; reset forces every output low in the same cycle.
  always_comb begin
    mem_read_req   = 2'b00;
    mem_write_req  = 2'b00;
    mem_addr_o     = 17'h00000;
    mem_write_data = 32'h00000000;
    wd_o           = 5'd0;
    wreg_o         = 1'b0;
    wdata_o        = 32'h00000000;
    stall_req      = 1'b0;
    if (rst) begin
      stall_req = 1'b0;
    end else begin
      mem_addr_o     = addr_q;
      mem_write_data = sdata_q;
      case (state_q)
        S_IDLE: begin
          wd_o    = wd_i;
          wdata_o = wdata_i;
          if (load_i || store_i) begin
            // The instruction is not finished yet, so nothing is written back.
            stall_req = 1'b1;
            wreg_o    = 1'b0;
          end else begin
            stall_req = 1'b0;
            wreg_o    = wreg_i;
          end
        end
        S_BUSY: begin
          stall_req = 1'b1;
          wd_o      = wd_q;
          if (is_load_q) begin
            mem_read_req = req_width(1'b1, funct3_q);
          end else begin
            mem_write_req = req_width(1'b0, funct3_q);
          end
        end
        S_DONE: begin
          // Requests already dropped so mem_buffer cannot re-latch the access.
          if (is_load_q) begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = rdata_q;
          end else begin
            wd_o    = wd_q;
          end
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// -----------------------------------------------------------------------------
// tb_mem_access -- self-checking bench for mem_access.
//
// Every operation is described at transaction level (issue cycle, N waiting
// cycles, one result cycle). The driver writes the expected outputs for each
// cycle; a single compare process checks them on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_i, store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i, mem_data_i;
  logic        mem_data_enable;
  logic [1:0]  mem_read_req, mem_write_req;
  logic [16:0] mem_addr_o;
  logic [31:0] mem_write_data;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stall_req;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .rst(rst), .load_i(load_i), .store_i(store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .store_data_i(store_data_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .mem_data_i(mem_data_i), .mem_data_enable(mem_data_enable),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req), .mem_addr_o(mem_addr_o),
    .mem_write_data(mem_write_data), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stall_req(stall_req)
  );

  // Expected values for the current cycle
  logic [1:0]  e_rreq, e_wreq;
  logic        e_stall, e_wreg;
  logic [4:0]  e_wd;
  logic [31:0] e_wdata, e_wdat;
  logic [16:0] e_addr;
  bit          chk_en = 1'b0, chk_data, chk_mem;
  string       tag = "none";
  int          vectors = 0, miscompares = 0;
  int          stall_run = 0;

  // ---------------- reference model (spec rules) ----------------
  function automatic logic [1:0] m_width(input bit ld, input logic [2:0] f3);
    int bytes;
    if (ld && (f3 == 3'd0 || f3 == 3'd4))      bytes = 1;
    else if (ld && (f3 == 3'd1 || f3 == 3'd5)) bytes = 2;
    else if (!ld && f3 == 3'd0)                bytes = 1;
    else if (!ld && f3 == 3'd1)                bytes = 2;
    else                                       bytes = 4;
    return (bytes == 1) ? 2'b01 : (bytes == 2) ? 2'b10 : 2'b11;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] d);
    int signed v;
    case (f3)
      3'd0:    begin v = int'($signed(d[7:0]));  return 32'(v); end
      3'd1:    begin v = int'($signed(d[15:0])); return 32'(v); end
      3'd4:    return d & 32'h000000FF;
      3'd5:    return d & 32'h0000FFFF;
      default: return d;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      bit bad;
      vectors++;
      bad = (mem_read_req !== e_rreq) || (mem_write_req !== e_wreq) ||
            (stall_req !== e_stall) || (wreg_o !== e_wreg);
      if (chk_data) bad = bad || (wd_o !== e_wd) || (wdata_o !== e_wdata);
      if (chk_mem)  bad = bad || (mem_addr_o !== e_addr) || (mem_write_data !== e_wdat);
      if (bad) begin
        miscompares++;
        $display("FAIL %s t=%0t got rreq=%b wreq=%b stall=%b wreg=%b wd=%0d wdata=%h addr=%h wdat=%h ; need rreq=%b wreq=%b stall=%b wreg=%b wd=%0d wdata=%h addr=%h wdat=%h (data_chk=%0d mem_chk=%0d)",
                 tag, $time, mem_read_req, mem_write_req, stall_req, wreg_o, wd_o, wdata_o,
                 mem_addr_o, mem_write_data, e_rreq, e_wreq, e_stall, e_wreg, e_wd, e_wdata,
                 e_addr, e_wdat, chk_data, chk_mem);
      end
      stall_run = stall_req ? stall_run + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_base(input logic [1:0] rr, input logic [1:0] wr, input logic st,
                             input logic wg);
    e_rreq = rr; e_wreq = wr; e_stall = st; e_wreg = wg;
    chk_data = 1'b0; chk_mem = 1'b0;
  endtask

  task automatic rand_inputs();
    load_i = 1'($urandom); store_i = 1'($urandom); funct3_i = 3'($urandom);
    addr_i = $urandom; store_data_i = $urandom; wd_i = 5'($urandom);
    wreg_i = 1'($urandom); wdata_i = $urandom; mem_data_i = $urandom;
  endtask

  // Non-memory instruction in IDLE: same-cycle passthrough.
  task automatic alu_op(input logic [4:0] wd, input logic [31:0] wv, input bit wr,
                        input bit en, input string t);
    rand_inputs();
    load_i = 1'b0; store_i = 1'b0; wd_i = wd; wdata_i = wv; wreg_i = wr;
    mem_data_enable = en;
    tag = t;
    expect_base(2'b00, 2'b00, 1'b0, wr);
    e_wd = wd; e_wdata = wv; chk_data = 1'b1;
    tick();
  endtask

  // One memory transaction: issue, nwait BUSY cycles (strobe on the last), DONE.
  task automatic mem_op(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] wd, input bit wr, input int nwait,
                        input logic [31:0] rd, input bit lit_en, input logic [31:0] lit,
                        input int rst_at, input string t);
    logic [1:0] w;
    bit eff_ld;
    eff_ld = ld;
    w = m_width(eff_ld, f3);
    tag = t;
    // issue cycle
    rand_inputs();
    load_i = ld; store_i = st; funct3_i = f3; addr_i = addr; store_data_i = sd;
    wd_i = wd; wreg_i = wr; mem_data_enable = 1'($urandom);
    expect_base(2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    // waiting cycles
    for (int k = 1; k <= nwait; k++) begin
      rand_inputs();
      mem_data_enable = (k == nwait);
      if (k == nwait) mem_data_i = rd;
      expect_base(eff_ld ? w : 2'b00, eff_ld ? 2'b00 : w, 1'b1, 1'b0);
      e_addr = addr[16:0]; e_wdat = sd; chk_mem = 1'b1;
      if (k == rst_at) begin
        rst = 1'b1;
        tag = {t, "_rst"};
        expect_base(2'b00, 2'b00, 1'b0, 1'b0);
        e_wd = 5'd0; e_wdata = 32'h0; e_addr = 17'h0; e_wdat = 32'h0;
        chk_data = 1'b1; chk_mem = 1'b1;
        tick();
        rst = 1'b0;
        tag = {t, "_after_rst"};
        rand_inputs();
        load_i = 1'b0; store_i = 1'b0; mem_data_enable = 1'b0;
        expect_base(2'b00, 2'b00, 1'b0, wreg_i);
        e_wd = wd_i; e_wdata = wdata_i; e_addr = 17'h0; e_wdat = 32'h0;
        chk_data = 1'b1; chk_mem = 1'b1;
        tick();
        return;
      end
      tick();
    end
    // result cycle: inputs are ignored
    rand_inputs();
    mem_data_enable = 1'($urandom);
    expect_base(2'b00, 2'b00, 1'b0, eff_ld ? wr : 1'b0);
    if (eff_ld) begin
      e_wd = wd;
      e_wdata = lit_en ? lit : m_ext(f3, rd);
      chk_data = 1'b1;
    end else begin
      chk_data = 1'b0;
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    load_i = 1'b0; store_i = 1'b0; funct3_i = 3'd0; addr_i = 32'h0; store_data_i = 32'h0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0; mem_data_i = 32'h0; mem_data_enable = 1'b0;
    tag = "reset";
    expect_base(2'b00, 2'b00, 1'b0, 1'b0);
    e_wd = 5'd0; e_wdata = 32'h0; e_addr = 17'h0; e_wdat = 32'h0;
    chk_data = 1'b1; chk_mem = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // directed cases with hand-computed results
    alu_op(5'd3, 32'h12345678, 1'b1, 1'b0, "alu_pass");
    mem_op(1, 0, 3'b000, 32'h00000104, 32'h0, 5'd5, 1, 5, 32'h00000080, 1, 32'hFFFFFF80, 0, "lb");
    if (stall_run != 0) begin
      miscompares++;
      $display("FAIL lb_stall_end got %0d need 0", stall_run);
    end
    mem_op(1, 0, 3'b101, 32'h00000200, 32'h0, 5'd7, 1, 2, 32'h0000F00F, 1, 32'h0000F00F, 0, "lhu");
    mem_op(1, 0, 3'b001, 32'h00000202, 32'h0, 5'd8, 1, 2, 32'h0000F00F, 1, 32'hFFFFF00F, 0, "lh");
    mem_op(0, 1, 3'b010, 32'hFFFFFFFF, 32'hDEADBEEF, 5'd9, 1, 3, 32'h0, 0, 32'h0, 0, "sw");
    alu_op(5'd1, 32'hCAFEF00D, 1'b0, 1'b0, "after_sw");
    mem_op(1, 1, 3'b000, 32'h00000010, 32'h55AA55AA, 5'd4, 1, 2, 32'h000000FF, 1, 32'hFFFFFFFF, 0, "ld_st_both");
    alu_op(5'd2, 32'h0000BEEF, 1'b1, 1'b1, "stray_en");
    alu_op(5'd6, 32'h00001234, 1'b1, 1'b0, "stray_en_next");
    mem_op(1, 0, 3'b010, 32'h00000040, 32'h0, 5'd10, 1, 4, 32'h11223344, 0, 32'h0, 2, "rst_busy");

    // randomized operations
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        alu_op(5'($urandom), $urandom, 1'($urandom), 1'($urandom), "rnd_alu");
      end else begin
        bit ld, st;
        ld = 1'($urandom);
        st = ld ? 1'($urandom) : 1'b1;
        mem_op(ld, st, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
               $urandom_range(1, 6), $urandom, 0, 32'h0,
               ($urandom_range(0, 19) == 0) ? 1 : 0, "rnd_mem");
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

MEM-stage load/store unit of the RISC-V pipeline and the requesting side of the `mem_buffer` data port. It turns a load/store from the EX/MEM register into a byte-count request, holds it until the buffer's completion strobe, then sign- or zero-extends load data. It stalls the pipeline for the duration of each memory access. Non-memory instructions pass straight through to MEM/WB.

## Interface
Parameters: none; `RegBus`=32, `RamAddrBus`=17 from `define.v`.
- clk  in  1  pipeline clock
- rst  in  1  synchronous reset, active-high (`RstEnable`)
- load_i  in  1  current EX/MEM instruction is a load
- store_i  in  1  current EX/MEM instruction is a store
- funct3_i  in  3  RISC-V funct3 of the load/store
- addr_i  in  32  effective address from ALU
- store_data_i  in  32  rs2 value for stores
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- wdata_i  in  32  ALU result (non-load write data)
- mem_data_i  in  32  load data from `mem_buffer` (`mem_data_o`)
- mem_data_enable  in  1  access-complete strobe from `mem_buffer`
- mem_read_req  out  2  read byte count: 00 none, 01 byte, 10 half, 11 word
- mem_write_req  out  2  write byte count, same encoding
- mem_addr_o  out  17  byte address to `mem_buffer`
- mem_write_data  out  32  store data, little-endian, LSB first
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stall_req  out  1  hold IF..EX/MEM stages

## Operation
- State machine: IDLE, BUSY, DONE.
- IDLE, no load/store: wd_o/wreg_o/wdata_o = inputs, combinationally; stall_req=0; requests 00.
- IDLE with load_i or store_i: stall_req=1 combinationally; on clk capture funct3, addr_i[16:0], store_data_i, wd_i, wreg_i; go BUSY. wreg_o=0 in this cycle.
- Load has priority if load_i and store_i are both set; store is ignored.
- BUSY: drive request from captured fields every cycle; stall_req=1; wreg_o=0. Hold until mem_data_enable=1 is sampled at clk. Then register the result and go DONE.
- Width from funct3:
  - Load: 000 LB→01 sign-extend bit 7; 001 LH→10 sign-extend bit 15; 010 LW→11; 100 LBU→01 zero-extend; 101 LHU→10 zero-extend; others→11 as LW.
  - Store: 000→01, 001→10, 010 and others→11.
- mem_write_data = captured store_data (full word); the buffer sends only the low bytes.
- DONE: requests forced 00; stall_req=0.
  - Load: wreg_o/wd_o = captured values; wdata_o = extended load data.
  - Store: wreg_o=0.
  - Always go to IDLE next clk. Inputs are ignored in DONE: EX/MEM still holds the finished instruction this cycle.
- Address: 17-bit truncation of addr_i. No alignment check; a misaligned half/word is issued as is.

## Timing
- Reset (any cycle, including BUSY): state=IDLE; all outputs 0: requests 00, mem_addr_o 0, mem_write_data 0, wd_o 0, wreg_o 0, wdata_o 0, stall_req 0; captured registers cleared. Both requests drop in the same cycle.
- Request is asserted from the first BUSY cycle. It stays constant until and including the cycle mem_data_enable is sampled.
- Request deasserts in DONE. `mem_buffer` then sees 00 when it returns to Inst_1 and must not re-latch the access.
- Load latency = 1 (IDLE) + N BUSY cycles + 1 (DONE), where N is the buffer's wait. Result is visible only in DONE.
- Non-memory instructions: 0 added latency, no stall.
- mem_data_enable seen in IDLE or DONE is ignored.
- Back-to-back memory ops: an op arriving right after DONE starts from IDLE. No request is issued in DONE.

## Test plan
- Reset in BUSY with mem_read_req=11: assert rst one cycle → next cycle requests 00, stall_req 0, state IDLE.
- LB, addr 0x00104, wd=5: respond mem_data_i=0x00000080 with enable after 4 cycles → mem_read_req=01 and mem_addr_o=0x00104 until enable. DONE shows wdata_o=0xFFFFFF80, wd_o=5, wreg_o=1. Stall high for exactly 6 cycles.
- LHU then LH, data 0x0000F00F → wdata_o=0x0000F00F, then 0xFFFFF00F; requests 10; a DONE cycle separates the two accesses.
- SW, addr 0x1FFFF (high addr bits set), data 0xDEADBEEF → mem_write_req=11, mem_addr_o=0x1FFFF, mem_write_data=0xDEADBEEF. DONE has wreg_o=0. Requests are 00 the cycle after enable.
- ALU op wd=3, wdata 0x12345678 in IDLE → same-cycle passthrough, stall_req 0, requests 00.
- load_i and store_i both set with funct3=000 → only mem_read_req=01; mem_write_req stays 00. A stray mem_data_enable in IDLE causes no state change.
